photosynthesis_array: RTL and testbench

- Parametrised, multi-channel successor of the single-leaf photosynthesis FSM.
- N_CH independent chloroplast channels each run absorption -> conversion -> production -> done, with timed dwell phases, resource timeouts and abort.
- A round-robin arbiter shares one carbon-fixation unit between channels. A saturating counter totals the oxygen produced.
- Sits under the plant-level controller. The per-channel oxygen pulses drive downstream gas accounting.

---
 rtl/photosynthesis_pkg.sv | 24 ++
 rtl/photosynthesis_channel.sv | 114 +++++++++++
 rtl/photosynthesis_array.sv | 112 +++++++++++
 tb/tb_photosynthesis_array.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/photosynthesis_pkg.sv
// Shared types and helpers for the multi-channel photosynthesis array.
// The state encoding is fixed because downstream tools decode channel state codes.
package photosynthesis_pkg;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_ABSORB  = 3'd1,
    PH_CONVERT = 3'd2,
    PH_PRODUCE = 3'd3,
    PH_DONE    = 3'd4,
    PH_ABORT   = 3'd5
  } ph_state_t;

  // Width for dwell/timeout counters: they only ever hold values up to max-1.
  function automatic int ph_cnt_width(input int abs_cycles, input int conv_cycles,
                                      input int timeout);
    int m;
    m = abs_cycles;
    if (conv_cycles > m) m = conv_cycles;
    if (timeout > m) m = timeout;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/photosynthesis_channel.sv
// One chloroplast channel: absorb -> convert -> produce -> done, with dwell and
// no-progress timeout counters. The fixation unit grant comes from the top-level arbiter.
module photosynthesis_channel
  import photosynthesis_pkg::*;
#(
  parameter int ABS_CYCLES  = 3,
  parameter int CONV_CYCLES = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_svjetlost,
  input  logic i_h2o,
  input  logic i_co2,
  input  logic i_grant,
  output logic o_req,
  output logic o_hold,
  output logic o_busy,
  output logic o_o2_pulse,
  output logic o_abort
);

  localparam int CW = ph_cnt_width(ABS_CYCLES, CONV_CYCLES, TIMEOUT);
  localparam logic [CW-1:0] ABS_LAST  = CW'(ABS_CYCLES - 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);

  ph_state_t       state_q, state_d;
  logic [CW-1:0]   dwell_q, dwell_d;
  logic [CW-1:0]   tmo_q, tmo_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= PH_IDLE;
      dwell_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    tmo_d   = tmo_q;
    case (state_q)
      PH_IDLE: begin
        if (i_en && i_svjetlost) begin
          state_d = PH_ABSORB;
          dwell_d = '0;
          tmo_d   = '0;
        end
      end
      PH_ABSORB: begin
        // Losing light while still absorbing is a silent return, not a failure.
        if (!i_svjetlost) begin
          state_d = PH_IDLE;
          dwell_d = '0;
          tmo_d   = '0;
        end else if (i_h2o) begin
          tmo_d = '0;
          if (dwell_q == ABS_LAST) begin
            state_d = PH_CONVERT;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end else begin
          dwell_d = '0;
          if (tmo_q == TMO_LAST) state_d = PH_ABORT;
          else                   tmo_d   = tmo_q + 1'b1;
        end
      end
      PH_CONVERT: begin
        if (i_grant && i_co2) begin
          state_d = PH_PRODUCE;
          dwell_d = '0;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = PH_ABORT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      PH_PRODUCE: begin
        if (dwell_q == CONV_LAST) state_d = PH_DONE;
        else                      dwell_d = dwell_q + 1'b1;
      end
      PH_DONE, PH_ABORT: begin
        state_d = PH_IDLE;
        dwell_d = '0;
        tmo_d   = '0;
      end
      default: begin
        state_d = PH_IDLE;
        dwell_d = '0;
        tmo_d   = '0;
      end
    endcase
  end

  // o_hold looks at the next state so the arbiter can drop the grant on the leaving edge.
  always_comb begin
    o_req      = (state_q == PH_CONVERT);
    o_hold     = (state_d == PH_CONVERT) || (state_d == PH_PRODUCE);
    o_busy     = (state_q != PH_IDLE);
    o_o2_pulse = (state_q == PH_DONE);
    o_abort    = (state_q == PH_ABORT);
  end

endmodule

// File: rtl/photosynthesis_array.sv
// N_CH photosynthesis channels sharing one carbon-fixation unit through a
// round-robin arbiter, plus a saturating total of completed productions.
module photosynthesis_array
  import photosynthesis_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int ABS_CYCLES  = 3,
  parameter int CONV_CYCLES = 4,
  parameter int TIMEOUT     = 16,
  parameter int O2_W        = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_CH-1:0]   i_en,
  input  logic              i_svjetlost,
  input  logic [N_CH-1:0]   i_h2o,
  input  logic [N_CH-1:0]   i_co2,
  output logic [N_CH-1:0]   o_busy,
  output logic [N_CH-1:0]   o_grant,
  output logic [N_CH-1:0]   o_o2_pulse,
  output logic [N_CH-1:0]   o_abort,
  output logic [O2_W-1:0]   o_o2_total
);

  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0] req;
  logic [N_CH-1:0] hold;
  logic [N_CH-1:0] pulse;
  logic [N_CH-1:0] grant_q, grant_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   holder;
  logic [O2_W-1:0] total_q, total_d;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      photosynthesis_channel #(
        .ABS_CYCLES (ABS_CYCLES),
        .CONV_CYCLES(CONV_CYCLES),
        .TIMEOUT    (TIMEOUT)
      ) u_ch (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_en       (i_en[gi]),
        .i_svjetlost(i_svjetlost),
        .i_h2o      (i_h2o[gi]),
        .i_co2      (i_co2[gi]),
        .i_grant    (grant_q[gi]),
        .o_req      (req[gi]),
        .o_hold     (hold[gi]),
        .o_busy     (o_busy[gi]),
        .o_o2_pulse (pulse[gi]),
        .o_abort    (o_abort[gi])
      );
    end
  endgenerate

  always_comb begin
    holder = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_q[i]) holder = PW'(i);
    end
  end

  // A busy unit is only ever released here; a new grant waits for the next edge,
  // which leaves one idle cycle between consecutive holders.
  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = '0;
    if (|grant_q) begin
      if (!hold[holder]) begin
        grant_d = '0;
        ptr_d   = PW'((int'(holder) + 1) % N_CH);
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        idx = PW'((int'(ptr_q) + k) % N_CH);
        if (!found && req[idx]) begin
          found        = 1'b1;
          grant_d[idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    total_d = total_q;
    if ((|pulse) && (total_q != {O2_W{1'b1}})) total_d = total_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      grant_q <= '0;
      ptr_q   <= '0;
      total_q <= '0;
    end else begin
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      total_q <= total_d;
    end
  end

  assign o_grant    = grant_q;
  assign o_o2_pulse = pulse;
  assign o_o2_total = total_q;

endmodule

// File: tb/tb_photosynthesis_array.sv
// Directed scenarios plus randomized traffic against a behavioural model of the
// array; two instances share stimulus, the second with a 2-bit oxygen total.
module tb_photosynthesis_array;

  localparam int N    = 4;
  localparam int ABS  = 3;
  localparam int CONV = 4;
  localparam int TMO  = 24;

  localparam int P_IDLE = 0, P_ABS = 1, P_CONV = 2, P_PROD = 3, P_DONE = 4, P_ABORT = 5;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] en, h2o, co2;
  logic         light;
  logic [N-1:0] busy, grant, pulse, abrt;
  logic [7:0]   total;
  logic [N-1:0] s_busy, s_grant, s_pulse, s_abrt;
  logic [1:0]   s_total;

  photosynthesis_array #(.N_CH(N), .ABS_CYCLES(ABS), .CONV_CYCLES(CONV), .TIMEOUT(TMO), .O2_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_svjetlost(light), .i_h2o(h2o), .i_co2(co2),
    .o_busy(busy), .o_grant(grant), .o_o2_pulse(pulse), .o_abort(abrt), .o_o2_total(total)
  );

  photosynthesis_array #(.N_CH(N), .ABS_CYCLES(ABS), .CONV_CYCLES(CONV), .TIMEOUT(TMO), .O2_W(2)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_svjetlost(light), .i_h2o(h2o), .i_co2(co2),
    .o_busy(s_busy), .o_grant(s_grant), .o_o2_pulse(s_pulse), .o_abort(s_abrt), .o_o2_total(s_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Behavioural model: phase per channel, consecutive-water run, dry/no-progress
  // count, remaining production cycles, unit owner (-1 = free) and pointer.
  int m_ph[N];
  int m_run[N];
  int m_dry[N];
  int m_left[N];
  int m_own;
  int m_ptr;
  int m_tot;
  int m_tot2;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_ph[c] = P_IDLE; m_run[c] = 0; m_dry[c] = 0; m_left[c] = 0;
    end
    m_own = -1; m_ptr = 0; m_tot = 0; m_tot2 = 0;
  endtask

  task automatic model_step();
    int nph[N];
    int nrun[N];
    int ndry[N];
    int nleft[N];
    int nown;
    int nptr;
    bit any_done;
    for (int c = 0; c < N; c++) begin
      nph[c] = m_ph[c]; nrun[c] = m_run[c]; ndry[c] = m_dry[c]; nleft[c] = m_left[c];
      case (m_ph[c])
        P_IDLE: if (en[c] && light) begin nph[c] = P_ABS; nrun[c] = 0; ndry[c] = 0; end
        P_ABS: begin
          if (!light) nph[c] = P_IDLE;
          else if (h2o[c]) begin
            nrun[c] = m_run[c] + 1; ndry[c] = 0;
            if (nrun[c] == ABS) nph[c] = P_CONV;
          end else begin
            nrun[c] = 0; ndry[c] = m_dry[c] + 1;
            if (ndry[c] == TMO) nph[c] = P_ABORT;
          end
        end
        P_CONV: begin
          if (m_own == c && co2[c]) begin nph[c] = P_PROD; nleft[c] = CONV; end
          else begin
            ndry[c] = m_dry[c] + 1;
            if (ndry[c] == TMO) nph[c] = P_ABORT;
          end
        end
        P_PROD: begin
          nleft[c] = m_left[c] - 1;
          if (nleft[c] == 0) nph[c] = P_DONE;
        end
        default: nph[c] = P_IDLE;
      endcase
    end
    nown = m_own; nptr = m_ptr;
    if (m_own >= 0) begin
      if (nph[m_own] != P_CONV && nph[m_own] != P_PROD) begin
        nown = -1; nptr = (m_own + 1) % N;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (nown < 0 && m_ph[c] == P_CONV) nown = c;
      end
    end
    any_done = 0;
    for (int c = 0; c < N; c++) if (m_ph[c] == P_DONE) any_done = 1;
    if (any_done) begin
      if (m_tot < 255) m_tot++;
      if (m_tot2 < 3) m_tot2++;
    end
    for (int c = 0; c < N; c++) begin
      m_ph[c] = nph[c]; m_run[c] = nrun[c]; m_dry[c] = ndry[c]; m_left[c] = nleft[c];
    end
    m_own = nown; m_ptr = nptr;
  endtask

  task automatic check_all();
    logic [N-1:0] eb, eg, ep, ea;
    for (int c = 0; c < N; c++) begin
      eb[c] = (m_ph[c] != P_IDLE);
      eg[c] = (m_own == c);
      ep[c] = (m_ph[c] == P_DONE);
      ea[c] = (m_ph[c] == P_ABORT);
      if (ep[c]) $display("cyc=%0d ch%0d o2 produced total=%0d", cyc, c, total);
      if (ea[c]) $display("cyc=%0d ch%0d aborted", cyc, c);
    end
    check_eq("busy", busy, eb);
    check_eq("grant", grant, eg);
    check_eq("o2_pulse", pulse, ep);
    check_eq("abort", abrt, ea);
    check_eq("o2_total", total, m_tot);
    check_eq("sat_grant", s_grant, eg);
    check_eq("sat_total", s_total, m_tot2);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic set_in(input logic [N-1:0] e, input logic l, input logic [N-1:0] w, input logic [N-1:0] c);
    en = e; light = l; h2o = w; co2 = c;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in('0, 1'b0, '0, '0);
    model_reset();
    #1;
    check_all();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all();
    end
    rst_n = 1'b1;
    cyc = 0;
  endtask

  int first_g, pcyc, pcnt, acnt, acyc, gseen, prevg, gidx, g_at_abort;
  int order[$];

  initial begin
    rst_n = 1'b0;
    set_in('0, 1'b0, '0, '0);
    do_reset();

    // Single channel, everything available: grant at 5, pulse at 10, idle at 11.
    set_in(4'b0001, 1'b1, 4'hF, 4'hF);
    cyc = 0; first_g = -1; pcyc = -1; pcnt = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) en = '0;
      if (grant[0] && first_g < 0) first_g = k;
      if (pulse[0]) begin pcnt++; pcyc = k; end
      if (k == 11) check_eq("t1_busy_c11", busy[0], 0);
    end
    check_eq("t1_grant_cyc", first_g, 5);
    check_eq("t1_pulse_cyc", pcyc, 10);
    check_eq("t1_pulse_cnt", pcnt, 1);
    check_eq("t1_total", total, 1);

    // Light lost during ABSORB cycle 2: idle at cycle 3, no abort.
    set_in(4'b0001, 1'b1, 4'hF, 4'hF);
    cyc = 0;
    step(); en = '0;
    step(); light = 1'b0;
    step();
    check_eq("t2_idle_c3", busy[0], 0);
    check_eq("t2_no_abort", abrt, 0);
    light = 1'b1;
    repeat (3) step();

    // Light lost during PRODUCE: completion still at cycle 10.
    set_in(4'b0001, 1'b1, 4'hF, 4'hF);
    cyc = 0; pcyc = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) en = '0;
      if (k == 7) light = 1'b0;
      if (pulse[0]) pcyc = k;
    end
    check_eq("t2_dark_pulse_cyc", pcyc, 10);
    light = 1'b1;

    // Channel 1 without water: exactly one abort after TMO dry cycles, never granted.
    set_in(4'b0010, 1'b1, 4'b1101, 4'hF);
    cyc = 0; acnt = 0; acyc = -1; gseen = 0;
    for (int k = 1; k <= TMO + 6; k++) begin
      step();
      if (k == 1) en = '0;
      if (abrt[1]) begin acnt++; acyc = k; end
      if (grant != 0) gseen++;
    end
    check_eq("t3_abort_cnt", acnt, 1);
    check_eq("t3_abort_cyc", acyc, TMO + 1);
    check_eq("t3_no_grant", gseen, 0);
    h2o = 4'hF;

    // All channels together, two rounds: grant order follows the pointer from 0.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      set_in(4'hF, 1'b1, 4'hF, 4'hF);
      cyc = 0; prevg = 0;
      order.delete();
      for (int k = 1; k <= 34; k++) begin
        step();
        if (k == 1) en = '0;
        if (grant != 0 && prevg == 0) begin
          gidx = -1;
          for (int i = 0; i < N; i++) if (grant[i]) gidx = i;
          order.push_back(gidx);
        end
        prevg = int'(grant);
      end
      check_eq("t4_grant_count", order.size(), 4);
      for (int i = 0; i < order.size() && i < 4; i++) check_eq("t4_order", order[i], i);
      check_eq("t4_total", total, 4 * (r + 1));
    end
    check_eq("t6_sat_total", s_total, 3);

    // Holder starves on CO2: abort releases the unit, the waiting channel follows.
    set_in(4'b0001, 1'b1, 4'hF, 4'b0010);
    cyc = 0; acyc = -1; first_g = -1; g_at_abort = -1;
    for (int k = 1; k <= 45; k++) begin
      step();
      if (k == 1 || k == 11) en = '0;
      if (k == 10) en = 4'b0010;
      if (abrt[0]) begin acyc = k; g_at_abort = int'(grant); end
      if (grant[1] && first_g < 0) first_g = k;
    end
    check_eq("t5_abort_cyc", acyc, TMO + 4);
    check_eq("t5_grant_at_abort", g_at_abort, 0);
    check_eq("t5_next_grant_cyc", first_g, TMO + 5);
    co2 = 4'hF;

    // Reset asserted mid-PRODUCE: outputs clear at once, nothing fires afterwards.
    set_in(4'b0001, 1'b1, 4'hF, 4'hF);
    cyc = 0;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 1) en = '0;
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_grant", grant, 0);
    check_eq("t6_rst_total", total, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all();
    end
    rst_n = 1'b1;
    pcnt = 0; acnt = 0;
    repeat (15) begin
      step();
      if (pulse != 0) pcnt++;
      if (abrt != 0) acnt++;
    end
    check_eq("t6_no_pulse", pcnt, 0);
    check_eq("t6_no_abort", acnt, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 2500; k++) begin
      en    = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      light = ($urandom_range(0, 19) != 0);
      for (int i = 0; i < N; i++) begin
        h2o[i] = ($urandom_range(0, 9) < 8);
        co2[i] = ($urandom_range(0, 9) < 7);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
